shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Command-driven controller that sequences an external N-bit bidirectional shift register (parallel load plus left/right shift).
- Accepts one command per transaction over a valid/ready handshake: data word, direction, shift count.
- Drives the register's load and shift strobes, exposes the bit shifted out each cycle as a serial stream, and pulses done at completion.
- Sits between a bus-side requester and the shift register datapath.

Parameters:
- N, 8, width of shift register and command data.
- CNT_W, $clog2(N+1), width of shift-count fields.

Ports:
- clk  input  1  clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_data  input  N  word to parallel-load.
- cmd_dir  input  1  0 = shift left (MSB out), 1 = shift right (LSB out).
- cmd_count  input  CNT_W  number of shifts; values >N clamp to N.
- abort  input  1  terminate current transaction.
- sr_load  output  1  load strobe to shift register.
- sr_shift_left  output  1  left-shift strobe.
- sr_shift_right  output  1  right-shift strobe.
- sr_in_data  output  N  parallel data to shift register.
- sr_q  input  N  shift register contents.
- ser_out  output  1  bit leaving the register this cycle.
- ser_valid  output  1  ser_out is meaningful.
- busy  output  1  transaction in progress (state != IDLE).
- done  output  1  one-cycle completion pulse.

Behaviour:
- FSM states: IDLE, LOAD, SHIFT, DONE. Registered state, data, dir and remaining count. Outputs are decoded from registered state; no input-to-output combinational path except the abort gating described below.
- Reset (reset_n low, asynchronous):
  - state = IDLE; captured data/dir/count = 0.
  - sr_in_data = 0; sr_load, sr_shift_left, sr_shift_right, ser_valid, ser_out, busy and done = 0.
  - cmd_ready = 0 while reset_n is low; cmd_ready = 1 in IDLE after release.
  - Reset mid-transaction discards the transaction silently, with no done pulse.
- IDLE:
  - cmd_ready = 1.
  - On a rising edge with cmd_valid & cmd_ready: capture cmd_data, cmd_dir, and min(cmd_count, N); go to LOAD.
- LOAD (1 cycle):
  - sr_load = 1.
  - Next state: DONE if captured count == 0, else SHIFT.
- SHIFT (count cycles):
  - sr_shift_left = 1 if dir = 0; sr_shift_right = 1 if dir = 1.
  - ser_valid = 1; ser_out = sr_q[N-1] (left) or sr_q[0] (right), i.e. the bit being shifted out this edge.
  - Remaining count decrements each cycle; when it is 1, next state is DONE.
- DONE (1 cycle):
  - done = 1, cmd_ready = 0.
  - Next state: IDLE. A cmd_valid held high here is accepted only in the following IDLE cycle.
- sr_in_data always equals the captured data register.
- Latency: accept at edge k → sr_load during cycle k+1 → shifts during cycles k+2 … k+1+count → done during cycle k+2+count → cmd_ready high in cycle k+3+count. With count = 0, done falls in cycle k+2.
- Throughput: one transaction per count+3 cycles.
- Abort:
  - Sampled in LOAD and SHIFT. When high, that cycle's sr_load and sr_shift_* strobes are forced to 0, and ser_valid is forced to 0.
  - Next state is IDLE with no done pulse. The register keeps whatever shifts already occurred.
  - Abort is ignored in IDLE and DONE.
- Invariants:
  - At most one of sr_load, sr_shift_left, sr_shift_right is high in any cycle.
  - busy = 1 exactly in LOAD, SHIFT and DONE.
  - cmd_ready and busy are never both 1.
- Count width rules: compare and clamp at full CNT_W; remaining count never underflows.

Decomposition:
- Package shift_seq_pkg:
  - State encoding: IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3.
  - Direction constants: DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1.
- Sub-module shift_seq_counter: loadable CNT_W down-counter with load, dec, and last (== 1) / zero flags. The FSM instantiates it for the remaining count.
- The bench instantiates shift_sequencer driving a shift_register of N = 8.

Test Plan:
- Reset: assert reset_n = 0 during the 3rd SHIFT cycle → all strobes, ser_valid, done, busy = 0 and cmd_ready = 0 immediately. After release: cmd_ready = 1, no done pulse.
- Left full: cmd_data 8'b10101010, dir 0, count 8 → 1 sr_load cycle, then 8 sr_shift_left cycles with ser_out 1,0,1,0,1,0,1,0 → done 1 cycle later, sr_q = 8'h00, cmd_ready the cycle after done.
- Right partial: cmd_data 8'hB4, dir 1, count 3 → ser_out 0,0,1 → sr_q = 8'h16, done at cycle k+5.
- Boundaries: count 0 with data 8'h5A → load only, done at cycle k+2, sr_q = 8'h5A, no shift strobes. Count 12 → clamped to exactly 8 shifts.
- Abort: abort high in the 3rd SHIFT cycle of a left, count 8, data 8'hFF transaction → exactly 2 shifts (sr_q = 8'hFC), no done, cmd_ready next cycle.
- Back-to-back: cmd_valid held high with two queued commands → second accepted only in IDLE after DONE. Check the one-hot strobe invariant and cmd_ready/busy exclusivity every cycle.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types for the shift sequencer: FSM state encoding and
// shift-direction constants used by the controller and its counter.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command handshake bundle between a requester and the shift sequencer.
// master: cmd_valid/data/dir/count out, cmd_ready in. slave: mirror.
interface shift_sequencer_if #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [N-1:0]     cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid,
    output cmd_data,
    output cmd_dir,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    input  cmd_dir,
    input  cmd_count,
    output cmd_ready
  );

endinterface

// File: rtl/shift_seq_counter.sv
// Loadable down-counter holding the remaining shift count.
// Ports: clk, rst_n, load_i/val_i (load), dec_i (step), last_o (==1), zero_o.
module shift_seq_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  input  logic             dec_i,
  output logic             last_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Decrement saturates at zero so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for an external N-bit bidirectional shift register.
// Ports: clk, reset_n, cmd (handshake if), abort, sr_* strobes/data, sr_q,
// ser_out/ser_valid serial tap, busy, done.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  shift_sequencer_if.slave cmd,
  input  logic             abort,
  output logic             sr_load,
  output logic             sr_shift_left,
  output logic             sr_shift_right,
  output logic [N-1:0]     sr_in_data,
  input  logic [N-1:0]     sr_q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  state_e       state_q;
  state_e       state_d;
  logic [N-1:0] data_q;
  logic [N-1:0] data_d;
  logic         dir_q;
  logic         dir_d;

  logic             ready;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_last;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_in;

  assign cnt_in = (cmd.cmd_count > N_CNT) ? N_CNT : cmd.cmd_count;

  shift_seq_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (reset_n),
    .load_i (cnt_load),
    .val_i  (cnt_in),
    .dec_i  (cnt_dec),
    .last_o (cnt_last),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      dir_q   <= DIR_LEFT;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
    end
  end

  // Abort only gates strobes and ser_valid; it never creates a path
  // from cmd inputs to outputs.
  always_comb begin
    state_d        = state_q;
    data_d         = data_q;
    dir_d          = dir_q;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    ready          = 1'b0;
    sr_load        = 1'b0;
    sr_shift_left  = 1'b0;
    sr_shift_right = 1'b0;
    ser_out        = 1'b0;
    ser_valid      = 1'b0;
    done           = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (cmd.cmd_valid) begin
          data_d   = cmd.cmd_data;
          dir_d    = cmd.cmd_dir;
          cnt_load = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          sr_load = 1'b1;
          state_d = cnt_zero ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        ser_out = (dir_q == DIR_RIGHT) ? sr_q[0] : sr_q[N-1];
        if (abort) begin
          state_d = IDLE;
        end else begin
          sr_shift_left  = (dir_q == DIR_LEFT);
          sr_shift_right = (dir_q == DIR_RIGHT);
          ser_valid      = 1'b1;
          cnt_dec        = 1'b1;
          state_d = (cnt_last || cnt_zero) ? DONE : SHIFT;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready is held low for the whole time reset is asserted.
  assign cmd.cmd_ready = ready & reset_n;
  assign sr_in_data    = data_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: shift_sequencer driving an 8-bit shift register,
// per-cycle expected output vectors queued at stimulus time.
module tb_shift_sequencer;

  logic       clk;
  logic       reset_n;
  logic       abort;
  logic       sr_load;
  logic       sr_shift_left;
  logic       sr_shift_right;
  logic [7:0] sr_in_data;
  logic [7:0] sr_q;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // {load, sl, sr, ser_valid, ser_out, done, busy, ready}
  typedef logic [7:0] vec_t;
  vec_t exp_q[$];

  shift_sequencer_if #(.N(8), .CNT_W(4)) cif ();

  shift_sequencer #(
    .N     (8),
    .CNT_W (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd            (cif),
    .abort          (abort),
    .sr_load        (sr_load),
    .sr_shift_left  (sr_shift_left),
    .sr_shift_right (sr_shift_right),
    .sr_in_data     (sr_in_data),
    .sr_q           (sr_q),
    .ser_out        (ser_out),
    .ser_valid      (ser_valid),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sr_q <= 8'h00;
    else if (sr_load) sr_q <= sr_in_data;
    else if (sr_shift_left) sr_q <= {sr_q[6:0], 1'b0};
    else if (sr_shift_right) sr_q <= {1'b0, sr_q[7:1]};
  end

  always @(negedge clk) begin
    checks++;
    if (int'(sr_load) + int'(sr_shift_left) + int'(sr_shift_right) > 1) begin
      errors++;
      $display("FAIL onehot: got %b%b%b want at most one high",
               sr_load, sr_shift_left, sr_shift_right);
    end
    checks++;
    if (cif.cmd_ready && busy) begin
      errors++;
      $display("FAIL ready_busy: got ready=1 busy=1 want not both");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic push_txn(input logic [7:0] d, input logic dir,
                          input logic [3:0] c, input int ab,
                          output logic [7:0] m);
    int eff;
    eff = (c > 4'd8) ? 8 : int'(c);
    m = d;
    exp_q.push_back(8'b1000_0010);
    for (int i = 1; i <= eff; i++) begin
      if (i == ab) begin
        exp_q.push_back(8'b0000_0010);
        exp_q.push_back(8'b0000_0001);
        return;
      end
      exp_q.push_back({1'b0, ~dir, dir, 1'b1,
                       dir ? m[0] : m[7], 1'b0, 1'b1, 1'b0});
      m = dir ? {1'b0, m[7:1]} : {m[6:0], 1'b0};
    end
    exp_q.push_back(8'b0000_0110);
    exp_q.push_back(8'b0000_0001);
  endtask

  task automatic present(input logic [7:0] d, input logic dir,
                         input logic [3:0] c);
    cif.cmd_valid = 1'b1;
    cif.cmd_data  = d;
    cif.cmd_dir   = dir;
    cif.cmd_count = c;
  endtask

  // Entered at posedge+1 with a command presented; leaves at posedge+1
  // after the trailing idle cycle.
  task automatic run_cycles(input string name, input int ab, input bit b2b,
                            input logic [7:0] d2, input logic dir2,
                            input logic [3:0] c2);
    int   j;
    bit   drop;
    vec_t e;
    vec_t o;
    j = 0;
    drop = 1'b0;
    @(negedge clk);
    checks++;
    if (cif.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: got ready=%b want 1", name, cif.cmd_ready);
    end
    @(posedge clk);
    #1;
    if (b2b) present(d2, dir2, c2);
    else cif.cmd_valid = 1'b0;
    while (exp_q.size() > 0) begin
      abort = (j == ab);
      @(negedge clk);
      e = exp_q.pop_front();
      o = {sr_load, sr_shift_left, sr_shift_right, ser_valid,
           ser_out, done, busy, cif.cmd_ready};
      if (!e[4]) begin
        o[3] = 1'b0;
        e[3] = 1'b0;
      end
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b want %b", name, j, o, e);
      end
      if (e[0] && cif.cmd_valid) drop = 1'b1;
      @(posedge clk);
      #1;
      if (drop) begin
        cif.cmd_valid = 1'b0;
        drop = 1'b0;
      end
      j++;
    end
    abort = 1'b0;
  endtask

  task automatic check_q(input string name, input logic [7:0] want);
    checks++;
    if (sr_q !== want) begin
      errors++;
      $display("FAIL %s sr_q: got %h want %h", name, sr_q, want);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({sr_load, sr_shift_left, sr_shift_right, ser_valid, ser_out,
         busy, done, cif.cmd_ready} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs: got %b want 00000000",
               {sr_load, sr_shift_left, sr_shift_right, ser_valid,
                ser_out, busy, done, cif.cmd_ready});
    end
    checks++;
    if (sr_in_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h want 00", sr_in_data);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cif.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b want 1 0",
               cif.cmd_ready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_left_full();
    logic [7:0] m;
    push_txn(8'hAA, 1'b0, 4'd8, -1, m);
    present(8'hAA, 1'b0, 4'd8);
    run_cycles("left_full", -1, 1'b0, 8'h00, 1'b0, 4'd0);
    check_q("left_full", 8'h00);
  endtask

  task automatic test_right_partial();
    logic [7:0] m;
    push_txn(8'hB4, 1'b1, 4'd3, -1, m);
    present(8'hB4, 1'b1, 4'd3);
    run_cycles("right_partial", -1, 1'b0, 8'h00, 1'b0, 4'd0);
    check_q("right_partial", 8'h16);
  endtask

  task automatic test_count_zero();
    logic [7:0] m;
    push_txn(8'h5A, 1'b0, 4'd0, -1, m);
    present(8'h5A, 1'b0, 4'd0);
    run_cycles("count_zero", -1, 1'b0, 8'h00, 1'b0, 4'd0);
    check_q("count_zero", 8'h5A);
  endtask

  task automatic test_count_clamp();
    logic [7:0] m;
    push_txn(8'hC3, 1'b1, 4'd12, -1, m);
    present(8'hC3, 1'b1, 4'd12);
    run_cycles("count_clamp", -1, 1'b0, 8'h00, 1'b0, 4'd0);
    check_q("count_clamp", 8'h00);
  endtask

  task automatic test_abort();
    logic [7:0] m;
    push_txn(8'hFF, 1'b0, 4'd8, 3, m);
    present(8'hFF, 1'b0, 4'd8);
    run_cycles("abort", 3, 1'b0, 8'h00, 1'b0, 4'd0);
    check_q("abort", 8'hFC);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ma;
    logic [7:0] mb;
    push_txn(8'h3C, 1'b0, 4'd2, -1, ma);
    push_txn(8'h81, 1'b1, 4'd1, -1, mb);
    present(8'h3C, 1'b0, 4'd2);
    run_cycles("back_to_back", -1, 1'b1, 8'h81, 1'b1, 4'd1);
    check_q("back_to_back", 8'h40);
  endtask

  task automatic test_reset_mid();
    present(8'hA5, 1'b0, 4'd8);
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sr_load, sr_shift_left, sr_shift_right, ser_valid,
         busy, done, cif.cmd_ready} !== 7'h00) begin
      errors++;
      $display("FAIL reset_mid_outs: got %b want 0000000",
               {sr_load, sr_shift_left, sr_shift_right, ser_valid,
                busy, done, cif.cmd_ready});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || cif.cmd_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after%0d: got done=%b ready=%b busy=%b want 0 1 0",
                 i, done, cif.cmd_ready, busy);
      end
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    abort         = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_data  = 8'h00;
    cif.cmd_dir   = 1'b0;
    cif.cmd_count = 4'd0;
    test_reset();
    test_left_full();
    test_right_partial();
    test_count_zero();
    test_count_clamp();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
